// File: rtl/aes_pkg.sv
// aes_pkg: shared AES state type, byte indexing and InvShiftRows helper
package aes_pkg;
  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_NB = 4;
  typedef logic [127:0] aes_state_t;
  function automatic int byte_pos(input int k);
    return 127 - 8 * k;
  endfunction
  // row r rotated right by r: s'[r][c] = s[r][(c-r) mod 4], byte index 4c+r
  function automatic aes_state_t isr(input aes_state_t s);
    aes_state_t r;
    r = '0;
    for (int c = 0; c < AES_NB; c++)
      for (int w = 0; w < 4; w++)
        r[byte_pos(4 * c + w) -: 8] = s[byte_pos(4 * ((c - w + 4) % 4) + w) -: 8];
    return r;
  endfunction
endpackage

// File: rtl/aes_inv_subbytes_stage_if.sv
// aes_inv_subbytes_stage_if: valid/ready input and output channels of the stage
interface aes_inv_subbytes_stage_if;
  import aes_pkg::*;
  logic in_valid;
  logic in_ready;
  aes_state_t in_state;
  logic out_valid;
  logic out_ready;
  aes_state_t out_state;
  logic busy;
  modport master(output in_valid, in_state, out_ready, input in_ready, out_valid, out_state, busy);
  modport slave(input in_valid, in_state, out_ready, output in_ready, out_valid, out_state, busy);
endinterface

// File: rtl/aes_inv_subbytes_stage_sbox.sv
// aes_inv_subbytes_stage_sbox: combinational AES inverse S-box (inverse affine, then GF(2^8) inverse)
module aes_inv_subbytes_stage_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p, v;
    p = '0;
    v = x;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (z[i] ? v : 8'h00);
      v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // x^254 is the multiplicative inverse, and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r, q;
    r = 8'h01;
    q = x;
    for (int i = 1; i < 8; i++) begin
      q = gmul(q, q);
      r = gmul(r, q);
    end
    return r;
  endfunction
  logic [7:0] t;
  assign t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
  assign y = ginv(t);
endmodule

// File: rtl/aes_inv_subbytes_stage.sv
// aes_inv_subbytes_stage: multi-cycle InvSubBytes over LANES bytes per cycle, optional InvShiftRows on capture
module aes_inv_subbytes_stage
  import aes_pkg::*;
#(
  parameter int LANES = 4,
  parameter bit INV_SHIFT = 1'b1
) (
  input logic clk,
  input logic rst_n,
  aes_inv_subbytes_stage_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
  localparam int NPASS = AES_BLOCK_BYTES / LANES;
  localparam int CW = NPASS > 1 ? $clog2(NPASS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NPASS - 1);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  aes_state_t work, sub_work;
  logic cap;
  logic [7:0] sb_in [LANES];
  logic [7:0] sb_out [LANES];
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign sb_in[l] = work[byte_pos(int'(cnt) * LANES + l) -: 8];
    aes_inv_subbytes_stage_sbox u_sbox (.a(sb_in[l]), .y(sb_out[l]));
  end
  always_comb begin
    sub_work = work;
    for (int l = 0; l < LANES; l++) sub_work[byte_pos(int'(cnt) * LANES + l) -: 8] = sb_out[l];
  end
  assign bus.in_ready = state == IDLE || (state == DONE && bus.out_ready);
  assign cap = bus.in_valid && bus.in_ready;
  assign bus.out_valid = state == DONE;
  assign bus.out_state = work;
  assign bus.busy = state != IDLE;
  always_comb begin
    nxt = state;
    nxt = cap ? SUB
        : state == SUB ? (cnt == LAST ? DONE : SUB)
        : state == DONE && !bus.out_ready ? DONE
        : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      work <= '0;
    end else begin
      state <= nxt;
      cnt <= cap ? '0 : (state == SUB && cnt != LAST) ? cnt + 1'b1 : cnt;
      work <= cap ? (INV_SHIFT ? isr(bus.in_state) : bus.in_state) : state == SUB ? sub_work : work;
    end
  end
endmodule

// File: tb/tb_aes_inv_subbytes_stage.sv
// tb_aes_inv_subbytes_stage: four stage variants driven in lockstep, checked against a table-built inverse S-box model
module tb_aes_inv_subbytes_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic iv = 1'b0;
  logic orr = 1'b0;
  logic [127:0] ist = '0;
  logic [3:0] ov, ir, bz;
  logic [127:0] os [4];
  int checks = 0;
  int errors = 0;
  logic [7:0] isb [256];
  localparam int EL [4] = '{4, 4, 16, 1};
  localparam bit SH [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    aes_inv_subbytes_stage_if b ();
    assign b.in_valid = iv;
    assign b.in_state = ist;
    assign b.out_ready = orr;
    assign ov[g] = b.out_valid;
    assign ir[g] = b.in_ready;
    assign bz[g] = b.busy;
    assign os[g] = b.out_state;
    aes_inv_subbytes_stage #(.LANES(g == 2 ? 1 : g == 3 ? 16 : 4), .INV_SHIFT(g != 1)) dut (
      .clk(clk), .rst_n(rst_n), .bus(b.slave));
  end

  function automatic logic [7:0] fmul(input logic [7:0] x, input logic [7:0] y);
    int a = x, b = y, p = 0;
    while (b != 0) begin
      if (b & 1) p = p ^ a;
      a = a << 1;
      if (a & 256) a = a ^ 'h11b;
      b = b >> 1;
    end
    return p[7:0];
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] w;
    w = {v, v} << n;
    return w[15:8];
  endfunction
  // Build the forward S-box from its definition, then invert it as a permutation
  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (fmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      isb[s] = 8'(x);
    end
  endtask
  function automatic logic [127:0] model(input logic [127:0] s, input bit sh);
    logic [7:0] m [4][4];
    logic [127:0] r;
    for (int c = 0; c < 4; c++) for (int w = 0; w < 4; w++) m[w][c] = s[127 - 8 * (4 * c + w) -: 8];
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127 - 8 * (4 * c + w) -: 8] = isb[m[w][sh ? (c - w + 4) % 4 : c]];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  task automatic start(input logic [127:0] s);
    @(negedge clk);
    chk("ready_before_accept", 128'(ir), 128'hf);
    iv = 1'b1;
    ist = s;
    @(posedge clk);
    #1 iv = 1'b0;
    chk("no_valid_at_accept", 128'(ov), 128'h0);
  endtask
  task automatic collect(input logic [127:0] s);
    int lat [4] = '{0, 0, 0, 0};
    for (int k = 1; k <= 40 && ov != 4'hf; k++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 4; g++) if (ov[g] && lat[g] == 0) lat[g] = k;
    end
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("latency_dut%0d", g), 128'(lat[g]), 128'(EL[g]));
      chk($sformatf("result_dut%0d", g), os[g], model(s, SH[g]));
    end
  endtask
  task automatic release_out();
    @(negedge clk);
    orr = 1'b1;
    @(posedge clk);
    #1 orr = 1'b0;
    chk("valid_drop", 128'(ov), 128'h0);
  endtask

  typedef struct {
    string nm;
    logic [127:0] in;
    logic [127:0] exp;
    bit sh;
  } vec_t;
  vec_t tbl [5];

  initial begin
    logic [127:0] held, nb;
    build_tables();
    tbl[0] = '{"fips_isr", 128'h7ad5fda789ef4e272bca100b3d9ff59f, 128'hbd6e7c3df2b5779e0b61216e8b10b689, 1'b1};
    tbl[1] = '{"fips_noshift", 128'h7a9f102789d5f50b2beffd9f3dca4ea7, 128'hbd6e7c3df2b5779e0b61216e8b10b689, 1'b0};
    tbl[2] = '{"all63", {16{8'h63}}, {16{8'h00}}, 1'b1};
    tbl[3] = '{"all00", {16{8'h00}}, {16{8'h52}}, 1'b1};
    tbl[4] = '{"allff", {16{8'hff}}, {16{8'h7d}}, 1'b1};
    iv = 1'b1;
    ist = {4{$urandom}};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(ir), 128'hf);
    chk("rst_out_valid", 128'(ov), 128'h0);
    chk("rst_busy", 128'(bz), 128'h0);
    for (int g = 0; g < 4; g++) chk($sformatf("rst_out_state_dut%0d", g), os[g], 128'h0);
    @(negedge clk);
    iv = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start(tbl[i].in);
      collect(tbl[i].in);
      for (int g = 0; g < 4; g++)
        if (SH[g] == tbl[i].sh) chk($sformatf("%s_dut%0d", tbl[i].nm, g), os[g], tbl[i].exp);
      release_out();
    end
    for (int i = 0; i < 6; i++) begin
      nb = {$urandom, $urandom, $urandom, $urandom};
      start(nb);
      collect(nb);
      release_out();
    end
    nb = {$urandom, $urandom, $urandom, $urandom};
    start(nb);
    collect(nb);
    held = os[0];
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("stall_out_state", os[0], held);
      chk("stall_in_ready", 128'(ir[0]), 128'h0);
      chk("stall_out_valid", 128'(ov[0]), 128'h1);
    end
    nb = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    iv = 1'b1;
    ist = nb;
    orr = 1'b1;
    #1 chk("b2b_in_ready", 128'(ir), 128'hf);
    @(posedge clk);
    #1 iv = 1'b0;
    orr = 1'b0;
    chk("b2b_busy", 128'(bz), 128'hf);
    chk("b2b_valid_low", 128'(ov), 128'h0);
    collect(nb);
    release_out();
    start({$urandom, $urandom, $urandom, $urandom});
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(ov), 128'h0);
    chk("midrst_busy", 128'(bz), 128'h0);
    chk("midrst_in_ready", 128'(ir), 128'hf);
    chk("midrst_out_state", os[0], 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    start({16{8'h63}});
    collect({16{8'h63}});
    chk("after_rst_all63", os[0], 128'h0);
    release_out();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
